// File: rtl/id_pkg.sv
// Purpose: shared defaults, control-field layout and FSM state encoding for the
//          decode-stage hazard/forwarding pipe.
package id_pkg;

    localparam int unsigned DEF_DATA_W  = 64;
    localparam int unsigned DEF_AW      = 5;
    localparam int unsigned DEF_CTRL_W  = 11;
    localparam int unsigned DEF_IMM_W   = 16;
    localparam int unsigned STALL_CNT_W = 16;

    // Packed control passthrough layout {op_code[6], WW[2], ppp[3]}
    localparam int unsigned CTRL_PPP_LSB = 0;
    localparam int unsigned CTRL_WW_LSB  = 3;
    localparam int unsigned CTRL_OP_LSB  = 5;

    // FSM state encoding
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

endpackage

// File: rtl/id_fwd_mux.sv
// Purpose: priority operand-forwarding mux over NUM_FWD ordered result sources.
// Ports:
//   src      in  AW              source register address
//   rf_data  in  DATA_W          register file read data (fallback)
//   fwd_rD   in  NUM_FWD*AW      destination per source (index 0 youngest)
//   fwd_wrEn in  NUM_FWD         write enable per source
//   fwd_data in  NUM_FWD*DATA_W  result per source
//   data_c   out DATA_W          selected operand (combinational)
module id_fwd_mux
    import id_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned R0_ZERO = 0
) (
    input  logic [AW-1:0]          src,
    input  logic [DATA_W-1:0]      rf_data,
    input  logic [NUM_FWD*AW-1:0]  fwd_rD,
    input  logic [NUM_FWD-1:0]     fwd_wrEn,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]      data_c
);

    logic src_blocked;

    assign src_blocked = (R0_ZERO != 0) && (src == '0);

    // Scan oldest to youngest so the lowest matching index wins
    always_comb begin
        data_c = rf_data;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_wrEn[i] && (fwd_rD[i*AW +: AW] == src) && !src_blocked) begin
                data_c = fwd_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/id_hazard_pipe.sv
// Purpose: decode-stage operand forwarding, load-use hazard stall/bubble FSM,
//          branch flush qualification and the ID/EX pipeline register.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   id_*                         decoded instruction in ID
//   rf_rA_data, rf_rS_data       register file read data
//   fwd_rD, fwd_wrEn, fwd_data   forwarding sources (index 0 youngest)
//   br_taken                     raw branch decision
//   ex_stall                     downstream back-pressure, freezes ID/EX
//   if_stall, if_flush           front-end control (combinational)
//   ex_*                         ID/EX register outputs
//   stall_cnt                    saturating hazard-stall cycle count
module id_hazard_pipe
    import id_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned NUM_FWD  = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CTRL_W   = DEF_CTRL_W,
    parameter int unsigned IMM_W    = DEF_IMM_W,
    parameter int unsigned R0_ZERO  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [AW-1:0]             id_rA,
    input  logic [AW-1:0]             id_rS,
    input  logic                      id_rA_use,
    input  logic                      id_rS_use,
    input  logic [AW-1:0]             id_rD,
    input  logic                      id_wrEn,
    input  logic                      id_memEn,
    input  logic                      id_memwrEn,
    input  logic [CTRL_W-1:0]         id_ctrl,
    input  logic [IMM_W-1:0]          id_imm,
    input  logic [DATA_W-1:0]         rf_rA_data,
    input  logic [DATA_W-1:0]         rf_rS_data,
    input  logic [NUM_FWD*AW-1:0]     fwd_rD,
    input  logic [NUM_FWD-1:0]        fwd_wrEn,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic                      br_taken,
    input  logic                      ex_stall,
    output logic                      if_stall,
    output logic                      if_flush,
    output logic                      ex_valid,
    output logic [AW-1:0]             ex_rD,
    output logic                      ex_wrEn,
    output logic                      ex_memEn,
    output logic                      ex_memwrEn,
    output logic [CTRL_W-1:0]         ex_ctrl,
    output logic [IMM_W-1:0]          ex_imm,
    output logic [DATA_W-1:0]         ex_rA_data,
    output logic [DATA_W-1:0]         ex_rS_data,
    output logic [STALL_CNT_W-1:0]    stall_cnt
);

    localparam int unsigned CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;

    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ex_valid_q, ex_valid_d;
    logic [AW-1:0]          ex_rD_q, ex_rD_d;
    logic                   ex_wrEn_q, ex_wrEn_d;
    logic                   ex_memEn_q, ex_memEn_d;
    logic                   ex_memwrEn_q, ex_memwrEn_d;
    logic [CTRL_W-1:0]      ex_ctrl_q, ex_ctrl_d;
    logic [IMM_W-1:0]       ex_imm_q, ex_imm_d;
    logic [DATA_W-1:0]      ex_rA_data_q, ex_rA_data_d;
    logic [DATA_W-1:0]      ex_rS_data_q, ex_rS_data_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [DATA_W-1:0] rA_fwd_c, rS_fwd_c;
    logic              ex_load_c, rA_hit_c, rS_hit_c, hazard_c, in_stall_c;

    id_fwd_mux #(.DATA_W(DATA_W), .AW(AW), .NUM_FWD(NUM_FWD), .R0_ZERO(R0_ZERO)) u_fwd_ra (
        .src(id_rA), .rf_data(rf_rA_data), .fwd_rD(fwd_rD), .fwd_wrEn(fwd_wrEn),
        .fwd_data(fwd_data), .data_c(rA_fwd_c)
    );

    id_fwd_mux #(.DATA_W(DATA_W), .AW(AW), .NUM_FWD(NUM_FWD), .R0_ZERO(R0_ZERO)) u_fwd_rs (
        .src(id_rS), .rf_data(rf_rS_data), .fwd_rD(fwd_rD), .fwd_wrEn(fwd_wrEn),
        .fwd_data(fwd_data), .data_c(rS_fwd_c)
    );

    // Load-use hazard against the instruction currently in EX
    assign ex_load_c  = ex_valid_q & ex_memEn_q & ~ex_memwrEn_q & ex_wrEn_q;
    assign rA_hit_c   = id_rA_use & (id_rA == ex_rD_q) & ~((R0_ZERO != 0) & (id_rA == '0));
    assign rS_hit_c   = id_rS_use & (id_rS == ex_rD_q) & ~((R0_ZERO != 0) & (id_rS == '0));
    assign hazard_c   = id_valid & ex_load_c & (rA_hit_c | rS_hit_c);
    assign in_stall_c = (state_q == ST_STALL);

    assign if_stall = ex_stall | hazard_c | in_stall_c;
    assign if_flush = id_valid & br_taken & ~if_stall;

    // Next-state: FSM, ID/EX load/bubble/hold, stall counter
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ex_valid_d   = ex_valid_q;
        ex_rD_d      = ex_rD_q;
        ex_wrEn_d    = ex_wrEn_q;
        ex_memEn_d   = ex_memEn_q;
        ex_memwrEn_d = ex_memwrEn_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_imm_d     = ex_imm_q;
        ex_rA_data_d = ex_rA_data_q;
        ex_rS_data_d = ex_rS_data_q;
        stall_cnt_d  = stall_cnt_q;

        if (!ex_stall) begin
            if (in_stall_c || hazard_c) begin
                // Bubble: clear the whole slot so nothing stale looks like a load
                ex_valid_d   = 1'b0;
                ex_rD_d      = '0;
                ex_wrEn_d    = 1'b0;
                ex_memEn_d   = 1'b0;
                ex_memwrEn_d = 1'b0;
                ex_ctrl_d    = '0;
                ex_imm_d     = '0;
                ex_rA_data_d = '0;
                ex_rS_data_d = '0;
                if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
                    stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
                end
                if (in_stall_c) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end else if (LOAD_LAT > 1) begin
                    cnt_d   = CNT_W'(LOAD_LAT - 1);
                    state_d = ST_STALL;
                end
            end else begin
                ex_valid_d   = id_valid;
                ex_rD_d      = id_rD;
                ex_wrEn_d    = id_wrEn;
                ex_memEn_d   = id_memEn;
                ex_memwrEn_d = id_memwrEn;
                ex_ctrl_d    = id_ctrl;
                ex_imm_d     = id_imm;
                ex_rA_data_d = rA_fwd_c;
                ex_rS_data_d = rS_fwd_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            ex_valid_q   <= 1'b0;
            ex_rD_q      <= '0;
            ex_wrEn_q    <= 1'b0;
            ex_memEn_q   <= 1'b0;
            ex_memwrEn_q <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_imm_q     <= '0;
            ex_rA_data_q <= '0;
            ex_rS_data_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ex_valid_q   <= ex_valid_d;
            ex_rD_q      <= ex_rD_d;
            ex_wrEn_q    <= ex_wrEn_d;
            ex_memEn_q   <= ex_memEn_d;
            ex_memwrEn_q <= ex_memwrEn_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_imm_q     <= ex_imm_d;
            ex_rA_data_q <= ex_rA_data_d;
            ex_rS_data_q <= ex_rS_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_rD      = ex_rD_q;
    assign ex_wrEn    = ex_wrEn_q;
    assign ex_memEn   = ex_memEn_q;
    assign ex_memwrEn = ex_memwrEn_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rA_data = ex_rA_data_q;
    assign ex_rS_data = ex_rS_data_q;
    assign stall_cnt  = stall_cnt_q;

endmodule
